// File: rtl/mp64_uart_host_pkg.sv
// rtl/mp64_uart_host_pkg.sv - shared UART register map, status bits and host FSM encoding
// Purpose: constants and types imported by the UART host, its bus interface and its skid registers.
// Ports: none.
package mp64_uart_host_pkg;

  // UART MMIO register offsets
  localparam logic [3:0] UART_TX      = 4'h0;
  localparam logic [3:0] UART_RX      = 4'h1;
  localparam logic [3:0] UART_STATUS  = 4'h2;
  localparam logic [3:0] UART_CONTROL = 4'h3;

  // STATUS register bit indices
  localparam int STAT_TX_READY = 0;
  localparam int STAT_RX_AVAIL = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STAT_REQ  = 3'd1,
    ST_STAT_WAIT = 3'd2,
    ST_TX_REQ    = 3'd3,
    ST_RX_REQ    = 3'd4,
    ST_XFER_WAIT = 3'd5
  } host_state_e;

  typedef enum logic {
    DIR_TX = 1'b0,
    DIR_RX = 1'b1
  } dir_e;

endpackage

// File: rtl/mp64_uart_host_if.sv
// rtl/mp64_uart_host_if.sv - MMIO register port between the UART host and the UART peripheral
// Purpose: groups the single-beat register bus.
// Signals: req (1-cycle request), addr[3:0], wdata[7:0], wen from the master;
//          rdata[7:0] and ack (one cycle after req) from the slave.
interface mp64_uart_host_if;
  logic       req;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       wen;
  logic [7:0] rdata;
  logic       ack;

  modport master (output req, output addr, output wdata, output wen,
                  input  rdata, input ack);
  modport slave  (input  req, input  addr, input  wdata, input  wen,
                  output rdata, output ack);
endinterface

// File: rtl/mp64_byte_skid.sv
// rtl/mp64_byte_skid.sv - one-entry byte holding register with valid flag
// Purpose: holds a single byte between a producer event (load) and a consumer event (clr).
// Ports: clk, rst_n (sync, active-low), load/load_data (capture a byte),
//        clr (drop the held byte), valid/data (held state).
module mp64_byte_skid (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       clr,
  output logic       valid,
  output logic [7:0] data
);

  logic       valid_q, valid_d;
  logic [7:0] data_q,  data_d;

  // Callers never load and clear in the same cycle; load wins if they did.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (clr) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/mp64_uart_host.sv
// rtl/mp64_uart_host.sv - bus initiator bridging byte streams to the UART MMIO registers
// Purpose: polls UART_STATUS, writes held TX bytes to UART_TX, reads UART_RX into an output register.
// Ports: clk, rst_n (sync, active-low), en (stop issuing new requests when low),
//        s_tdata/s_tvalid/s_tready (TX bytes in), m_tdata/m_tvalid/m_tready (RX bytes out),
//        bus (MMIO master port), err (sticky ack timeout).
module mp64_uart_host
  import mp64_uart_host_pkg::*;
#(
  parameter int unsigned POLL_GAP    = 16,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned RX_FIRST    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [7:0]               s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  output logic [7:0]               m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  mp64_uart_host_if.master         bus,
  output logic                     err
);

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);
  localparam logic [7:0] TO_LAST  = 8'(ACK_TIMEOUT - 1);

  host_state_e state_q, state_d;
  logic [7:0]  gap_q,   gap_d;
  logic [7:0]  wait_q,  wait_d;
  dir_e        prio_q,  prio_d;
  dir_e        xdir_q,  xdir_d;
  logic        err_q,   err_d;

  logic       tx_hold_v;
  logic [7:0] tx_hold_data;
  logic       tx_load, tx_done, rx_done, tx_pending;
  logic       rx_ok, tx_ok;
  dir_e       pick;
  logic       req_o, wen_o;
  logic [3:0] addr_o;
  logic [7:0] wdata_o;

  assign tx_load    = s_tvalid && !tx_hold_v;
  // A byte captured this cycle counts as held so the STATUS poll starts next cycle.
  assign tx_pending = tx_hold_v || tx_load;

  mp64_byte_skid u_tx_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tx_load),
    .load_data (s_tdata),
    .clr       (tx_done),
    .valid     (tx_hold_v),
    .data      (tx_hold_data)
  );

  mp64_byte_skid u_rx_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (rx_done),
    .load_data (bus.rdata),
    .clr       (m_tvalid && m_tready),
    .valid     (m_tvalid),
    .data      (m_tdata)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    wait_d  = wait_q;
    prio_d  = prio_q;
    xdir_d  = xdir_q;
    err_d   = err_q;
    tx_done = 1'b0;
    rx_done = 1'b0;
    rx_ok   = 1'b0;
    tx_ok   = 1'b0;
    pick    = prio_q;
    req_o   = 1'b0;
    wen_o   = 1'b0;
    addr_o  = 4'h0;
    wdata_o = 8'h00;

    case (state_q)
      ST_IDLE: begin
        wait_d = 8'h00;
        if (en && tx_pending) begin
          state_d = ST_STAT_REQ;
          gap_d   = 8'h00;
        end else if (en && !m_tvalid) begin
          if (gap_q == GAP_LAST) begin
            state_d = ST_STAT_REQ;
            gap_d   = 8'h00;
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end else begin
          gap_d = 8'h00;
        end
      end

      ST_STAT_REQ: begin
        req_o   = 1'b1;
        addr_o  = UART_STATUS;
        wait_d  = 8'h00;
        state_d = ST_STAT_WAIT;
      end

      ST_STAT_WAIT: begin
        if (bus.ack) begin
          wait_d = 8'h00;
          rx_ok  = bus.rdata[STAT_RX_AVAIL] && !m_tvalid;
          tx_ok  = bus.rdata[STAT_TX_READY] && tx_hold_v;
          if (rx_ok && tx_ok) pick = prio_q;
          else if (rx_ok)     pick = DIR_RX;
          else                pick = DIR_TX;
          // en dropping mid-poll lets the poll finish but starts no transfer.
          if (en && (rx_ok || tx_ok)) begin
            state_d = (pick == DIR_RX) ? ST_RX_REQ : ST_TX_REQ;
            xdir_d  = pick;
            prio_d  = (pick == DIR_RX) ? DIR_TX : DIR_RX;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (wait_q == TO_LAST) begin
          err_d   = 1'b1;
          wait_d  = 8'h00;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      ST_TX_REQ: begin
        req_o   = 1'b1;
        wen_o   = 1'b1;
        addr_o  = UART_TX;
        wdata_o = tx_hold_data;
        wait_d  = 8'h00;
        state_d = ST_XFER_WAIT;
      end

      ST_RX_REQ: begin
        req_o   = 1'b1;
        addr_o  = UART_RX;
        wait_d  = 8'h00;
        state_d = ST_XFER_WAIT;
      end

      ST_XFER_WAIT: begin
        if (bus.ack) begin
          tx_done = (xdir_q == DIR_TX);
          rx_done = (xdir_q == DIR_RX);
          wait_d  = 8'h00;
          state_d = ST_IDLE;
        end else if (wait_q == TO_LAST) begin
          // Held TX byte stays put and will be retried after the next poll.
          err_d   = 1'b1;
          wait_d  = 8'h00;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gap_q   <= 8'h00;
      wait_q  <= 8'h00;
      prio_q  <= (RX_FIRST != 0) ? DIR_RX : DIR_TX;
      xdir_q  <= DIR_TX;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      wait_q  <= wait_d;
      prio_q  <= prio_d;
      xdir_q  <= xdir_d;
      err_q   <= err_d;
    end
  end

  assign bus.req   = req_o;
  assign bus.wen   = wen_o;
  assign bus.addr  = addr_o;
  assign bus.wdata = wdata_o;
  assign s_tready  = !tx_hold_v;
  assign err       = err_q;

endmodule

// File: tb/tb_mp64_uart_host.sv
// tb/tb_mp64_uart_host.sv - directed self-checking bench for mp64_uart_host
module tb_mp64_uart_host;

  localparam logic [3:0] A_TX   = 4'h0;
  localparam logic [3:0] A_RX   = 4'h1;
  localparam logic [3:0] A_STAT = 4'h2;

  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [7:0] s_tdata, m_tdata;
  logic       s_tvalid, s_tready, m_tvalid, m_tready, err;

  always #5 clk = ~clk;

  mp64_uart_host_if bus ();

  mp64_uart_host #(.POLL_GAP(16), .ACK_TIMEOUT(15), .RX_FIRST(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .bus      (bus),
    .err      (err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Responder model state
  int         req_cnt = 0, stat_cnt = 0, tx_cnt = 0, rx_cnt = 0, stat_at_tx = 0;
  logic [7:0] last_wdata = 8'h00, def_status = 8'h00, rx_byte = 8'h00;
  logic       no_ack = 1'b0;
  logic [7:0] stat_q[$];
  logic [3:0] op_log[$];

  // UART register responder: acks one cycle after each req.
  initial begin : responder
    logic       p_req, p_wen;
    logic [3:0] p_addr;
    logic [7:0] p_wdata;
    bus.ack   = 1'b0;
    bus.rdata = 8'h00;
    forever begin
      @(negedge clk);
      p_req   = bus.req;
      p_wen   = bus.wen;
      p_addr  = bus.addr;
      p_wdata = bus.wdata;
      @(posedge clk);
      #1;
      bus.ack   = 1'b0;
      bus.rdata = 8'h00;
      if (p_req) begin
        req_cnt++;
        if (!no_ack) begin
          bus.ack = 1'b1;
          if (p_wen) begin
            tx_cnt++;
            last_wdata = p_wdata;
            stat_at_tx = stat_cnt;
            op_log.push_back(p_addr);
          end else if (p_addr == A_STAT) begin
            stat_cnt++;
            if (stat_q.size() > 0) bus.rdata = stat_q.pop_front();
            else                   bus.rdata = def_status;
          end else if (p_addr == A_RX) begin
            rx_cnt++;
            bus.rdata = rx_byte;
            op_log.push_back(p_addr);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic quiesce();
    en = 1'b0;
    tick(40);
  endtask

  task automatic wait_tx(input int target, input string tag);
    int n = 0;
    while (tx_cnt < target && n < 300) begin
      tick(1);
      n++;
    end
    check(tag, int'(tx_cnt >= target), 1);
  endtask

  task automatic wait_mvalid(input string tag);
    int n = 0;
    while (!m_tvalid && n < 300) begin
      tick(1);
      n++;
    end
    check(tag, int'(m_tvalid), 1);
  endtask

  initial begin : stim
    int sb, tb0, rb, rq;
    rst_n = 1'b0; en = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; m_tready = 1'b0;
    tick(3);
    check("rst_req",      int'(bus.req),   0);
    check("rst_wen",      int'(bus.wen),   0);
    check("rst_addr",     int'(bus.addr),  0);
    check("rst_wdata",    int'(bus.wdata), 0);
    check("rst_s_tready", int'(s_tready),  1);
    check("rst_m_tvalid", int'(m_tvalid),  0);
    check("rst_m_tdata",  int'(m_tdata),   0);
    check("rst_err",      int'(err),       0);

    // TX path, minimum latency: byte offered in cycle 0
    stat_q.push_back(8'h01);
    rst_n = 1'b1; en = 1'b1; s_tdata = 8'h41; s_tvalid = 1'b1;
    check("tx_c0_ready", int'(s_tready), 1);
    tick(1); s_tvalid = 1'b0;
    check("tx_c1_req",   int'(bus.req),  1);
    check("tx_c1_addr",  int'(bus.addr), int'(A_STAT));
    check("tx_c1_wen",   int'(bus.wen),  0);
    check("tx_c1_ready", int'(s_tready), 0);
    tick(1);
    check("tx_c2_req",   int'(bus.req),  0);
    check("tx_c2_ready", int'(s_tready), 0);
    tick(1);
    check("tx_c3_req",   int'(bus.req),   1);
    check("tx_c3_wen",   int'(bus.wen),   1);
    check("tx_c3_addr",  int'(bus.addr),  int'(A_TX));
    check("tx_c3_wdata", int'(bus.wdata), 8'h41);
    check("tx_c3_ready", int'(s_tready),  0);
    tick(1);
    check("tx_c4_ready", int'(s_tready), 0);
    tick(1);
    check("tx_c5_ready", int'(s_tready), 1);
    check("tx_count",    tx_cnt,         1);
    check("tx_stat_cnt", stat_cnt,       1);
    check("tx_wdata",    int'(last_wdata), 8'h41);

    // TX backpressure: three not-ready polls, then ready
    quiesce();
    sb = stat_cnt; tb0 = tx_cnt;
    stat_q.push_back(8'h00); stat_q.push_back(8'h00);
    stat_q.push_back(8'h00); stat_q.push_back(8'h01);
    en = 1'b1; s_tdata = 8'h42; s_tvalid = 1'b1;
    tick(1); s_tvalid = 1'b0;
    wait_tx(tb0 + 1, "bp_wait");
    tick(3);
    check("bp_polls_before_tx", stat_at_tx - sb, 4);
    check("bp_tx_count",        tx_cnt - tb0,    1);
    check("bp_wdata",           int'(last_wdata), 8'h42);
    check("bp_ready",           int'(s_tready),   1);

    // RX path with consumer stalled
    quiesce();
    rb = rx_cnt; rx_byte = 8'h5A; m_tready = 1'b0;
    stat_q.push_back(8'h02);
    en = 1'b1;
    wait_mvalid("rx_wait1");
    check("rx_data1",  int'(m_tdata), 8'h5A);
    check("rx_count1", rx_cnt - rb,   1);
    def_status = 8'h02;
    tick(60);
    check("rx_stall_count",  rx_cnt - rb,     1);
    check("rx_stall_mvalid", int'(m_tvalid),  1);
    rx_byte = 8'h5B; m_tready = 1'b1;
    tick(1); m_tready = 1'b0;
    check("rx_hs_clear", int'(m_tvalid), 0);
    wait_mvalid("rx_wait2");
    check("rx_data2",  int'(m_tdata), 8'h5B);
    check("rx_count2", rx_cnt - rb,   2);
    def_status = 8'h00; m_tready = 1'b1;
    tick(1); m_tready = 1'b0;
    check("rx_drain", int'(m_tvalid), 0);

    // Arbitration from a fresh reset (RX priority first)
    en = 1'b0; rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    op_log.delete();
    stat_q.push_back(8'h03); stat_q.push_back(8'h03);
    rx_byte = 8'h61; m_tready = 1'b1; tb0 = tx_cnt;
    en = 1'b1; s_tdata = 8'h44; s_tvalid = 1'b1;
    tick(1); s_tvalid = 1'b0;
    wait_tx(tb0 + 1, "arb_wait1");
    tick(3);
    check("arb_ops1", op_log.size(), 2);
    check("arb_op0",  int'(op_log[0]), int'(A_RX));
    check("arb_op1",  int'(op_log[1]), int'(A_TX));
    quiesce();
    stat_q.push_back(8'h03); stat_q.push_back(8'h03);
    en = 1'b1; s_tdata = 8'h45; s_tvalid = 1'b1;
    tick(1); s_tvalid = 1'b0;
    wait_tx(tb0 + 2, "arb_wait2");
    tick(3);
    check("arb_ops2",   op_log.size(), 4);
    check("arb_op2",    int'(op_log[2]), int'(A_RX));
    check("arb_op3",    int'(op_log[3]), int'(A_TX));
    check("arb_wdata",  int'(last_wdata), 8'h45);
    check("arb_rxdata", int'(m_tdata),    8'h61);

    // Ack timeout: req in cycle 1, fifteen wait cycles, err visible in cycle 17
    quiesce();
    m_tready = 1'b0;
    tb0 = tx_cnt; no_ack = 1'b1;
    en = 1'b1; s_tdata = 8'h46; s_tvalid = 1'b1;
    tick(1); s_tvalid = 1'b0;
    check("to_c1_req", int'(bus.req), 1);
    tick(15);
    check("to_c16_err", int'(err), 0);
    tick(1);
    check("to_c17_err",   int'(err),      1);
    check("to_c17_req",   int'(bus.req),  0);
    check("to_c17_ready", int'(s_tready), 0);
    stat_q.push_back(8'h01); no_ack = 1'b0;
    wait_tx(tb0 + 1, "to_wait");
    tick(3);
    check("to_tx_count", tx_cnt - tb0,     1);
    check("to_wdata",    int'(last_wdata), 8'h46);
    check("to_ready",    int'(s_tready),   1);
    check("to_err_sticky", int'(err),      1);

    // en low with a byte held: no requests
    quiesce();
    rq = req_cnt;
    s_tdata = 8'h47; s_tvalid = 1'b1;
    tick(1); s_tvalid = 1'b0;
    tick(40);
    check("en0_no_req", req_cnt - rq,    0);
    check("en0_held",   int'(s_tready),  0);

    // Reset during XFER_WAIT
    stat_q.push_back(8'h01);
    en = 1'b1;
    tick(1);
    check("rx_c1_stat_req", int'(bus.req), 1);
    tick(2);
    check("rx_c3_tx_req", int'(bus.req), 1);
    check("rx_c3_tx_wen", int'(bus.wen), 1);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_req",      int'(bus.req),   0);
    check("mid_rst_wen",      int'(bus.wen),   0);
    check("mid_rst_addr",     int'(bus.addr),  0);
    check("mid_rst_wdata",    int'(bus.wdata), 0);
    check("mid_rst_s_tready", int'(s_tready),  1);
    check("mid_rst_m_tvalid", int'(m_tvalid),  0);
    check("mid_rst_m_tdata",  int'(m_tdata),   0);
    check("mid_rst_err",      int'(err),       0);
    rst_n = 1'b1; en = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
